// File: rtl/queue_cmd_driver_pkg.sv
// queue_cmd_driver_pkg: opcodes, command field layout and driver FSM states
package queue_cmd_driver_pkg;
   localparam int CMD_W  = 18;
   localparam int DATA_W = 16;
   localparam int OP_HI  = 17;
   localparam int OP_LO  = 16;
   typedef enum logic [1:0] {
      OP_PUSH     = 2'b00,
      OP_POP      = 2'b01,
      OP_PUSHPREV = 2'b10,
      OP_IDLE     = 2'b11
   } op_e;
   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_WAIT_BUSY = 2'd1,
      S_WAIT_DONE = 2'd2,
      S_RESP      = 2'd3
   } state_e;
endpackage

// File: rtl/queue_cmd_fifo.sv
// queue_cmd_fifo: circular command buffer; pushes are refused while full
module queue_cmd_fifo
   import queue_cmd_driver_pkg::*;
#(
   parameter int DEPTH = 8,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [CMD_W-1:0] din,
   output logic [CMD_W-1:0] dout,
   output logic [AW:0]      count,
   output logic             full,
   output logic             empty
);
   logic [CMD_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]    head_q, head_d, tail_q, tail_d;
   logic [AW:0]      count_q, count_d;
   logic             do_push, do_pop;
   always_comb begin
      full    = count_q == (AW+1)'(DEPTH);
      empty   = count_q == '0;
      do_push = push && !full;
      do_pop  = pop && !empty;
      head_d  = do_pop ? head_q + 1'b1 : head_q;
      tail_d  = do_push ? tail_q + 1'b1 : tail_q;
      count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
      count   = count_q;
      dout    = mem_q[head_q];
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end
   always_ff @(posedge clk) begin
      if (do_push) mem_q[tail_q] <= din;
   end
endmodule

// File: rtl/queue_cmd_driver.sv
// queue_cmd_driver: buffers host commands, issues each as a one-cycle go pulse,
// tracks the ready drop/rise handshake and returns one response per command
module queue_cmd_driver
   import queue_cmd_driver_pkg::*;
#(
   parameter int DEPTH   = 8,
   parameter int TIMEOUT = 15,
   parameter int ERRW    = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_valid,
   input  logic [17:0]      cmd_in,
   output logic             cmd_ready,
   input  logic             q_ready,
   input  logic             q_error,
   input  logic [15:0]      q_rdata,
   output logic             q_go,
   output logic [17:0]      q_cmd,
   output logic             rsp_valid,
   output logic [1:0]       rsp_op,
   output logic [15:0]      rsp_data,
   output logic             rsp_error,
   output logic             rsp_timeout,
   output logic             busy,
   output logic [ERRW-1:0]  err_count
);
   localparam int AW = $clog2(DEPTH);
   localparam int TW = $clog2(TIMEOUT + 1);
   state_e            state_q, state_d;
   logic [TW-1:0]     wait_q, wait_d;
   logic              q_go_q, q_go_d;
   logic [CMD_W-1:0]  q_cmd_q, q_cmd_d;
   logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
   logic              rsp_error_q, rsp_error_d;
   logic              rsp_timeout_q, rsp_timeout_d;
   logic [ERRW-1:0]   err_count_q, err_count_d;
   logic [CMD_W-1:0]  fifo_dout;
   logic [AW:0]       fifo_count;
   logic              fifo_full, fifo_empty;
   logic              issue, waiting, expired, done_ok, timeout_hit;

   queue_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (cmd_valid),
      .pop   (issue),
      .din   (cmd_in),
      .dout  (fifo_dout),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // a legitimate handshake edge wins over a timeout landing in the same cycle
   always_comb begin
      issue       = (state_q == S_IDLE) && !fifo_empty && q_ready;
      waiting     = (state_q == S_WAIT_BUSY) || (state_q == S_WAIT_DONE);
      expired     = waiting && (wait_q == TW'(TIMEOUT - 1));
      done_ok     = (state_q == S_WAIT_DONE) && q_ready;
      timeout_hit = expired && !done_ok && !((state_q == S_WAIT_BUSY) && !q_ready);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= S_IDLE;
         wait_q        <= '0;
         q_go_q        <= 1'b0;
         q_cmd_q       <= '0;
         rsp_data_q    <= '0;
         rsp_error_q   <= 1'b0;
         rsp_timeout_q <= 1'b0;
         err_count_q   <= '0;
      end else begin
         state_q       <= state_d;
         wait_q        <= wait_d;
         q_go_q        <= q_go_d;
         q_cmd_q       <= q_cmd_d;
         rsp_data_q    <= rsp_data_d;
         rsp_error_q   <= rsp_error_d;
         rsp_timeout_q <= rsp_timeout_d;
         err_count_q   <= err_count_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:      state_d = issue ? S_WAIT_BUSY : S_IDLE;
         S_WAIT_BUSY: state_d = !q_ready ? S_WAIT_DONE : timeout_hit ? S_RESP : S_WAIT_BUSY;
         S_WAIT_DONE: state_d = (done_ok || timeout_hit) ? S_RESP : S_WAIT_DONE;
         S_RESP:      state_d = S_IDLE;
         default:     state_d = S_IDLE;
      endcase
   end

   // wait counter restarts on every state change so each wait state gets its own budget
   always_comb begin
      wait_d        = (waiting && state_d == state_q) ? wait_q + 1'b1 : '0;
      q_go_d        = issue;
      q_cmd_d       = issue ? fifo_dout : q_cmd_q;
      rsp_data_d    = done_ok ? ((q_cmd_q[OP_HI:OP_LO] == OP_POP) ? q_rdata : '0)
                    : timeout_hit ? '0 : rsp_data_q;
      rsp_error_d   = done_ok ? q_error : timeout_hit ? 1'b1 : rsp_error_q;
      rsp_timeout_d = done_ok ? 1'b0 : timeout_hit ? 1'b1 : rsp_timeout_q;
      err_count_d   = (state_q == S_RESP && rsp_error_q && err_count_q != '1)
                    ? err_count_q + 1'b1 : err_count_q;
      cmd_ready     = !fifo_full;
      q_go          = q_go_q;
      q_cmd         = q_cmd_q;
      rsp_valid     = state_q == S_RESP;
      rsp_op        = q_cmd_q[OP_HI:OP_LO];
      rsp_data      = rsp_data_q;
      rsp_error     = rsp_error_q;
      rsp_timeout   = rsp_timeout_q;
      busy          = (state_q != S_IDLE) || (fifo_count != '0);
      err_count     = err_count_q;
   end
endmodule

// File: doc/queue_cmd_driver.md
Name: queue_cmd_driver

Overview:
- Initiator for the queue controller's go/cmd/ready command interface.
- Buffers host commands in a small FIFO and issues them one at a time, each as a single-cycle go pulse.
- Tracks the ready drop/rise to detect completion, then returns one response per command with the error flag and POP data.
- Sits between host/test logic and the queue controller.

Parameters:
- DEPTH, 8, command buffer entries (power of 2).
- TIMEOUT, 15, max cycles in WAIT_BUSY or WAIT_DONE before the command is aborted.
- ERRW, 8, width of err_count.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- cmd_valid  in  1  host offers cmd_in.
- cmd_in  in  18  [17:16] opcode (PUSH=00, POP=01, PUSHPREV=10, IDLE=11), [15:0] data.
- cmd_ready  out  1  buffer not full; combinational.
- q_ready  in  1  queue controller ready.
- q_error  in  1  queue controller error flag.
- q_rdata  in  16  popped data from queue memory.
- q_go  out  1  registered go pulse.
- q_cmd  out  18  registered command to queue.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_op  out  2  opcode of completed command.
- rsp_data  out  16  q_rdata for POP, else 0.
- rsp_error  out  1  q_error at completion, or timeout.
- rsp_timeout  out  1  command aborted by timeout.
- busy  out  1  FSM not in S_IDLE or buffer non-empty.
- err_count  out  ERRW  saturating count of rsp_error responses.

Behaviour:
- Clock/reset: single clock. Reset is synchronous, active-high, named reset; clock named clk.
- Reset values: all registered outputs 0; FSM S_IDLE; buffer empty; err_count 0.
  - Reset mid-command drops buffer contents and the in-flight command with no response.
- Command buffer: circular, head/tail wrap at DEPTH-1 to 0, count 0..DEPTH.
  - Push when cmd_valid && cmd_ready.
  - cmd_ready = (count != DEPTH); a push is refused when full, even in a cycle that pops.
  - Same-cycle push and pop on a non-full buffer keep count unchanged.
- FSM states:
  - S_IDLE: if buffer non-empty and q_ready=1, pop head into q_cmd, set q_go=1, go to S_WAIT_BUSY.
  - S_WAIT_BUSY: q_go cleared unconditionally, so go is exactly one cycle. When q_ready=0, go to S_WAIT_DONE.
  - S_WAIT_DONE: on q_ready=1, go to S_RESP, capturing q_error and q_rdata that cycle.
  - S_RESP: rsp_valid=1 for one cycle, then S_IDLE. Next issue is no earlier than the following cycle.
- Timing: q_go is high in cycle t, q_ready low at t+1, response data valid when q_ready is 1 again (t+3 nominal). rsp_valid is asserted at t+4.
- Timeout:
  - A wait counter resets on entry to each wait state.
  - Reaching TIMEOUT in either wait state goes to S_RESP with rsp_error=1, rsp_timeout=1, rsp_data=0.
- IDLE opcode (11) is issued like any other command and completes normally with rsp_error=q_error.
- err_count increments on each rsp_valid with rsp_error=1 and saturates at all-ones.
- q_cmd holds its last value after issue; the queue samples it only while go=1.

Decomposition:
- Shared header/package: opcode constants PUSH/POP/PUSHPREV/IDLE and the 18-bit command field positions, shared with the queue controller.
- One sub-module: queue_cmd_fifo (DEPTH x 18 circular buffer with count/full/empty). The FSM, timeout counter and response capture stay in the top.

Test Plan:
- Reset, push cmd 0x0_00AB (PUSH 0xAB) with queue model idle -> q_go one cycle with q_cmd=0x000AB; rsp_valid 4 cycles later, rsp_op=00, rsp_error=0, rsp_data=0.
- PUSH 0x1234 then POP, model returns q_rdata=0x1234 -> second response rsp_op=01, rsp_data=0x1234; go pulses never overlap.
- POP on empty model queue (q_error=1 at completion) -> rsp_error=1, err_count=1; PUSHPREV with no prior pop -> err_count=2.
- Fill buffer with 8 commands while q_ready=0 -> cmd_ready=0 after 8th push; 9th refused; release q_ready -> 8 responses in order, cmd_ready returns after first issue.
- Hold q_ready=1 permanently after go (stuck model) -> after 15 cycles rsp_valid with rsp_timeout=1, rsp_error=1, and the FSM issues the next command.
- Assert reset while in S_WAIT_DONE with 3 buffered commands -> next cycle all outputs 0, cmd_ready=1, no rsp_valid.
